// File: rtl/lock_relock_pkg.sv
// Shared definitions for the lock/relock supervisor: state codes and widths.
package lock_relock_pkg;

  localparam int STATE_W  = 3;
  localparam int RELOCK_W = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_TRACK  = 3'd1,
    ST_LOCKED = 3'd2,
    ST_SWEEP  = 3'd3,
    ST_CATCH  = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

endpackage

// File: rtl/lock_relock_sweep.sv
// Triangle generator for the integrator reset value: step divider, clamp to
// [min,max], direction flip on the cycle a bound is hit.
// Optional macro LOCK_RELOCK_TIMEOUT_EN exposes the bound-hit pulse.
module lock_relock_sweep #(
  parameter int DW = 14,
  parameter int CW = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clr_i,
  input  logic                 load_i,
  input  logic                 run_i,
  input  logic signed [DW-1:0] min_i,
  input  logic signed [DW-1:0] max_i,
  input  logic        [DW-1:0] step_i,
  input  logic        [CW-1:0] div_i,
`ifdef LOCK_RELOCK_TIMEOUT_EN
  output logic                 hit_o,
`endif
  output logic signed [DW-1:0] val_o
);

  logic signed [DW-1:0] val_q, val_d;
  logic                 up_q, up_d;
  logic        [CW-1:0] div_q, div_d;
  logic                 hit;

  // Two guard bits so a full-scale step from a full-scale value cannot wrap.
  logic signed [DW+1:0] val_x, step_x, min_x, max_x, sum;

  assign val_x  = {{2{val_q[DW-1]}}, val_q};
  assign step_x = {2'b00, step_i};
  assign min_x  = {{2{min_i[DW-1]}}, min_i};
  assign max_x  = {{2{max_i[DW-1]}}, max_i};

  // Candidate next value and whether this step lands on (or past) a bound.
  always_comb begin
    sum = up_q ? (val_x + step_x) : (val_x - step_x);
    hit = 1'b0;
    if (div_q == '0 && min_i <= max_i && step_i != '0)
      hit = up_q ? (sum >= max_x) : (sum <= min_x);
  end

`ifdef LOCK_RELOCK_TIMEOUT_EN
  assign hit_o = hit;
`endif

  // Next value: clear, load at sweep entry, or divided step with clamp/reverse.
  always_comb begin
    val_d = val_q;
    up_d  = up_q;
    div_d = div_q;
    if (clr_i) begin
      val_d = '0;
      up_d  = 1'b1;
      div_d = '0;
    end else if (load_i) begin
      val_d = min_i;
      up_d  = 1'b1;
      div_d = div_i;
    end else if (run_i) begin
      if (div_q != '0) begin
        div_d = div_q - CW'(1);
      end else begin
        div_d = div_i;
        if (min_i > max_i) begin
          val_d = min_i;
        end else if (step_i != '0) begin
          if (hit) begin
            val_d = up_q ? max_i : min_i;
            up_d  = !up_q;
          end else begin
            val_d = sum[DW-1:0];
          end
        end
      end
    end
  end

  // Sweep registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      val_q <= '0;
      up_q  <= 1'b1;
      div_q <= '0;
    end else begin
      val_q <= val_d;
      up_q  <= up_d;
      div_q <= div_d;
    end
  end

  assign val_o = val_q;

endmodule

// File: rtl/lock_relock_ctrl.sv
// Lock/relock supervisor for the PID block: declares lock and loss of lock,
// reacquires by sweeping the integrator reset value.
// Optional macro LOCK_RELOCK_TIMEOUT_EN adds sweep_tmo_i and the FAULT exit.
//
// state  | meaning
// IDLE   | disarmed, all control outputs low
// TRACK  | counting good/bad cycles toward lock or unlock
// LOCKED | locked_o high, watching for loss of lock
// SWEEP  | integrator held in reset, reset value swept as a triangle
// CATCH  | integrator released, waiting settle_i cycles
// FAULT  | sweep timed out, PID frozen until disabled
module lock_relock_ctrl
  import lock_relock_pkg::*;
#(
  parameter int DW = 14,
  parameter int CW = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 enable_i,
  input  logic signed [DW-1:0] err_i,
  input  logic signed [DW-1:0] ctrl_i,
  input  logic        [DW-1:0] win_i,
  input  logic        [DW-1:0] sat_thr_i,
  input  logic        [CW-1:0] lock_cnt_i,
  input  logic        [CW-1:0] unlock_cnt_i,
  input  logic signed [DW-1:0] sweep_min_i,
  input  logic signed [DW-1:0] sweep_max_i,
  input  logic        [DW-1:0] sweep_step_i,
  input  logic        [CW-1:0] sweep_div_i,
  input  logic        [CW-1:0] settle_i,
`ifdef LOCK_RELOCK_TIMEOUT_EN
  input  logic        [CW-1:0] sweep_tmo_i,
`endif
  output logic                 pid_freeze_o,
  output logic                 pid_ifreeze_o,
  output logic                 int_rst_o,
  output logic signed [DW-1:0] int_rst_val_o,
  output logic                 locked_o,
  output logic [STATE_W-1:0]   state_o,
  output logic [RELOCK_W-1:0]  relock_cnt_o
);

  state_e                state_q, state_d;
  logic [CW-1:0]         good_q, good_d, bad_q, bad_d, tmr_q, tmr_d;
  logic [RELOCK_W-1:0]   relock_q, relock_d;
  logic                  freeze_q, freeze_d, ifreeze_q, ifreeze_d;
  logic                  int_rst_q, int_rst_d, locked_q, locked_d;
  logic [DW:0]           err_x, ctrl_x, err_mag, ctrl_mag;
  logic                  in_win, railed, bad;
  logic [CW-1:0]         lock_eff, unlock_eff;
  logic                  tmo_hit;
  logic                  sw_clr, sw_load, sw_run;

  // Magnitudes in DW+1 bits so the most negative input is exact.
  assign err_x    = {err_i[DW-1], err_i};
  assign ctrl_x   = {ctrl_i[DW-1], ctrl_i};
  assign err_mag  = err_x[DW]  ? (~err_x + 1'b1)  : err_x;
  assign ctrl_mag = ctrl_x[DW] ? (~ctrl_x + 1'b1) : ctrl_x;
  assign in_win   = err_mag <= {1'b0, win_i};
  assign railed   = ctrl_mag >= {1'b0, sat_thr_i};
  assign bad      = !in_win || railed;

  assign lock_eff   = (lock_cnt_i == '0)   ? CW'(1) : lock_cnt_i;
  assign unlock_eff = (unlock_cnt_i == '0) ? CW'(1) : unlock_cnt_i;

`ifdef LOCK_RELOCK_TIMEOUT_EN
  logic          sw_hit;
  logic [CW-1:0] rev_q, rev_d;

  assign tmo_hit = (state_q == ST_SWEEP) && !in_win && sw_hit && (sweep_tmo_i != '0)
                   && (({1'b0, rev_q} + (CW+1)'(1)) >= {1'b0, sweep_tmo_i});

  // Bound reversals seen in the current sweep; cleared outside SWEEP.
  always_comb begin
    rev_d = '0;
    if (state_q == ST_SWEEP)
      rev_d = (sw_run && sw_hit && rev_q != '1) ? rev_q + CW'(1) : rev_q;
  end

  // Reversal counter register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rev_q <= '0;
    else         rev_q <= rev_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next state, run counters, settle timer and relock counter.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    relock_d = relock_q;
    case (state_q)
      ST_IDLE:   if (enable_i) state_d = ST_TRACK;
      ST_TRACK: begin
        if (bad_q >= unlock_eff)     state_d = ST_SWEEP;
        else if (good_q >= lock_eff) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (bad_q >= unlock_eff) begin
          state_d  = ST_SWEEP;
          relock_d = (relock_q == '1) ? relock_q : relock_q + RELOCK_W'(1);
        end
      end
      ST_SWEEP: begin
        if (in_win) begin
          state_d = ST_CATCH;
          tmr_d   = settle_i;
        end else if (tmo_hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_CATCH: begin
        if (tmr_q <= CW'(1)) state_d = ST_TRACK;
        else                 tmr_d   = tmr_q - CW'(1);
      end
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase
    if (!enable_i) state_d = ST_IDLE;

    good_d = '0;
    bad_d  = '0;
    if ((state_q == ST_TRACK || state_q == ST_LOCKED) &&
        (state_d == ST_TRACK || state_d == ST_LOCKED)) begin
      good_d = bad  ? '0 : ((good_q == '1) ? good_q : good_q + CW'(1));
      bad_d  = !bad ? '0 : ((bad_q == '1)  ? bad_q  : bad_q + CW'(1));
    end
  end

  // Registered outputs follow the state being entered.
  always_comb begin
    freeze_d  = (state_d == ST_FAULT);
    ifreeze_d = (state_d == ST_SWEEP) || (state_d == ST_FAULT);
    int_rst_d = (state_d == ST_SWEEP);
    locked_d  = (state_d == ST_LOCKED);
  end

  assign sw_clr  = (state_d == ST_IDLE);
  assign sw_load = (state_d == ST_SWEEP) && (state_q != ST_SWEEP);
  assign sw_run  = (state_q == ST_SWEEP) && enable_i && !in_win;

  lock_relock_sweep #(.DW(DW), .CW(CW)) u_sweep (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (sw_clr),
    .load_i (sw_load),
    .run_i  (sw_run),
    .min_i  (sweep_min_i),
    .max_i  (sweep_max_i),
    .step_i (sweep_step_i),
    .div_i  (sweep_div_i),
`ifdef LOCK_RELOCK_TIMEOUT_EN
    .hit_o  (sw_hit),
`endif
    .val_o  (int_rst_val_o)
  );

  // State, counters and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      good_q    <= '0;
      bad_q     <= '0;
      tmr_q     <= '0;
      relock_q  <= '0;
      freeze_q  <= 1'b0;
      ifreeze_q <= 1'b0;
      int_rst_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      tmr_q     <= tmr_d;
      relock_q  <= relock_d;
      freeze_q  <= freeze_d;
      ifreeze_q <= ifreeze_d;
      int_rst_q <= int_rst_d;
      locked_q  <= locked_d;
    end
  end

  assign pid_freeze_o  = freeze_q;
  assign pid_ifreeze_o = ifreeze_q;
  assign int_rst_o     = int_rst_q;
  assign locked_o      = locked_q;
  assign state_o       = state_q;
  assign relock_cnt_o  = relock_q;

endmodule

// File: tb/tb_lock_relock_ctrl.sv
// Directed bench for lock_relock_ctrl; timeout scenario runs only when
// LOCK_RELOCK_TIMEOUT_EN is defined.
module tb_lock_relock_ctrl;

  logic               clk = 1'b0;
  logic               rstn;
  logic               enable;
  logic signed [13:0] err, ctrl, smin, smax;
  logic        [13:0] win, sat, step;
  logic        [15:0] lockc, unlockc, div, settle, tmo;
  logic               freeze, ifreeze, int_rst, locked;
  logic signed [13:0] val;
  logic        [2:0]  state;
  logic        [15:0] relock;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lock_relock_ctrl #(.DW(14), .CW(16)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .enable_i      (enable),
    .err_i         (err),
    .ctrl_i        (ctrl),
    .win_i         (win),
    .sat_thr_i     (sat),
    .lock_cnt_i    (lockc),
    .unlock_cnt_i  (unlockc),
    .sweep_min_i   (smin),
    .sweep_max_i   (smax),
    .sweep_step_i  (step),
    .sweep_div_i   (div),
    .settle_i      (settle),
`ifdef LOCK_RELOCK_TIMEOUT_EN
    .sweep_tmo_i   (tmo),
`endif
    .pid_freeze_o  (freeze),
    .pid_ifreeze_o (ifreeze),
    .int_rst_o     (int_rst),
    .int_rst_val_o (val),
    .locked_o      (locked),
    .state_o       (state),
    .relock_cnt_o  (relock)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; enable = 1'b0; err = 14'sd50; ctrl = 14'sd0;
    win = 14'd100; sat = 14'd8000; lockc = 16'd10; unlockc = 16'd5;
    smin = -14'sd1000; smax = 14'sd1000; step = 14'd300; div = 16'd0;
    settle = 16'd20; tmo = 16'd0;
    tick(3);
    n_chk++;
    if ({freeze, ifreeze, int_rst, locked} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {freeze, ifreeze, int_rst, locked});
    end
    n_chk++;
    if (state !== 3'd0 || val !== 14'sd0 || relock !== 16'd0) begin
      n_fail++; $display("FAIL reset_regs: state %0d val %0d relock %0d, want 0 0 0", state, val, relock);
    end
    rstn = 1'b1;
    tick(2);
    n_chk++;
    if (state !== 3'd0) begin
      n_fail++; $display("FAIL idle_disabled: state %0d want 0", state);
    end
  endtask

  task automatic test_lock;
    enable = 1'b1;
    tick(1);
    n_chk++;
    if (state !== 3'd1) begin
      n_fail++; $display("FAIL track_entry: state %0d want 1", state);
    end
    tick(10);
    n_chk++;
    if (locked !== 1'b0 || state !== 3'd1) begin
      n_fail++; $display("FAIL lock_early: locked %b state %0d want 0 1", locked, state);
    end
    tick(1);
    n_chk++;
    if (locked !== 1'b1 || state !== 3'd2) begin
      n_fail++; $display("FAIL lock_at_11: locked %b state %0d want 1 2", locked, state);
    end
  endtask

  task automatic test_unlock;
    err = 14'sd500;
    tick(4);
    err = 14'sd50;
    tick(2);
    n_chk++;
    if (state !== 3'd2 || locked !== 1'b1) begin
      n_fail++; $display("FAIL unlock_4bad: state %0d locked %b want 2 1", state, locked);
    end
    err = 14'sd500;
    tick(5);
    n_chk++;
    if (state !== 3'd2) begin
      n_fail++; $display("FAIL unlock_5th_edge: state %0d want 2", state);
    end
    tick(1);
    n_chk++;
    if (state !== 3'd3 || relock !== 16'd1 || locked !== 1'b0) begin
      n_fail++; $display("FAIL unlock_sweep: state %0d relock %0d locked %b want 3 1 0", state, relock, locked);
    end
    n_chk++;
    if (int_rst !== 1'b1 || ifreeze !== 1'b1 || freeze !== 1'b0 || val !== -14'sd1000) begin
      n_fail++; $display("FAIL sweep_entry: rst %b ifrz %b frz %b val %0d want 1 1 0 -1000", int_rst, ifreeze, freeze, val);
    end
  endtask

  task automatic test_sweep;
    int exp_seq[15] = '{-700, -400, -100, 200, 500, 800, 1000, 700, 400, 100,
                        -200, -500, -800, -1000, -700};
    for (int i = 0; i < 15; i++) begin
      tick(1);
      n_chk++;
      if (int'(val) != exp_seq[i] || state !== 3'd3) begin
        n_fail++; $display("FAIL sweep_step%0d: val %0d state %0d want %0d 3", i, val, state, exp_seq[i]);
      end
    end
  endtask

  task automatic test_catch;
    tick(2);
    n_chk++;
    if (val !== -14'sd100) begin
      n_fail++; $display("FAIL catch_pre: val %0d want -100", val);
    end
    err = 14'sd0;
    tick(1);
    n_chk++;
    if (state !== 3'd4 || val !== -14'sd100 || int_rst !== 1'b0 || ifreeze !== 1'b0) begin
      n_fail++; $display("FAIL catch_entry: state %0d val %0d rst %b ifrz %b want 4 -100 0 0", state, val, int_rst, ifreeze);
    end
    err = 14'sd500;
    tick(19);
    n_chk++;
    if (state !== 3'd4) begin
      n_fail++; $display("FAIL settle_19: state %0d want 4", state);
    end
    tick(1);
    n_chk++;
    if (state !== 3'd1) begin
      n_fail++; $display("FAIL settle_20: state %0d want 1", state);
    end
    tick(5);
    n_chk++;
    if (state !== 3'd1) begin
      n_fail++; $display("FAIL track_bad5: state %0d want 1", state);
    end
    tick(1);
    n_chk++;
    if (state !== 3'd3 || relock !== 16'd1 || val !== -14'sd1000) begin
      n_fail++; $display("FAIL track_to_sweep: state %0d relock %0d val %0d want 3 1 -1000", state, relock, val);
    end
  endtask

  task automatic test_enable_off;
    tick(3);
    enable = 1'b0;
    tick(1);
    n_chk++;
    if (state !== 3'd0 || {freeze, ifreeze, int_rst, locked} !== 4'b0000 || val !== 14'sd0) begin
      n_fail++; $display("FAIL disable_sweep: state %0d flags %b val %0d want 0 0000 0", state, {freeze, ifreeze, int_rst, locked}, val);
    end
    n_chk++;
    if (relock !== 16'd1) begin
      n_fail++; $display("FAIL relock_kept: relock %0d want 1", relock);
    end
  endtask

  task automatic test_rail;
    unlockc = 16'd3; err = -14'sd100; ctrl = 14'sd0; enable = 1'b1;
    tick(12);
    n_chk++;
    if (state !== 3'd2) begin
      n_fail++; $display("FAIL rail_lock_edge_win: state %0d want 2", state);
    end
    ctrl = 14'sd8000;
    tick(3);
    n_chk++;
    if (state !== 3'd2) begin
      n_fail++; $display("FAIL rail_3: state %0d want 2", state);
    end
    tick(1);
    n_chk++;
    if (state !== 3'd3 || relock !== 16'd2) begin
      n_fail++; $display("FAIL rail_sweep: state %0d relock %0d want 3 2", state, relock);
    end
  endtask

  task automatic test_sweep_div;
    enable = 1'b0;
    tick(1);
    div = 16'd2; unlockc = 16'd1; ctrl = 14'sd0; err = 14'sd500; enable = 1'b1;
    tick(2);
    n_chk++;
    if (state !== 3'd1) begin
      n_fail++; $display("FAIL div_track: state %0d want 1", state);
    end
    tick(1);
    n_chk++;
    if (state !== 3'd3 || val !== -14'sd1000) begin
      n_fail++; $display("FAIL div_entry: state %0d val %0d want 3 -1000", state, val);
    end
    tick(2);
    n_chk++;
    if (val !== -14'sd1000) begin
      n_fail++; $display("FAIL div_hold: val %0d want -1000", val);
    end
    tick(1);
    n_chk++;
    if (val !== -14'sd700) begin
      n_fail++; $display("FAIL div_step: val %0d want -700", val);
    end
    tick(3);
    n_chk++;
    if (val !== -14'sd400) begin
      n_fail++; $display("FAIL div_step2: val %0d want -400", val);
    end
  endtask

`ifdef LOCK_RELOCK_TIMEOUT_EN
  task automatic test_timeout;
    enable = 1'b0;
    tick(1);
    div = 16'd0; tmo = 16'd2; enable = 1'b1;
    tick(3);
    tick(13);
    n_chk++;
    if (state !== 3'd3 || val !== -14'sd800) begin
      n_fail++; $display("FAIL tmo_before: state %0d val %0d want 3 -800", state, val);
    end
    tick(1);
    n_chk++;
    if (state !== 3'd5 || freeze !== 1'b1 || ifreeze !== 1'b1 || int_rst !== 1'b0) begin
      n_fail++; $display("FAIL tmo_fault: state %0d frz %b ifrz %b rst %b want 5 1 1 0", state, freeze, ifreeze, int_rst);
    end
    tmo = 16'd0;
  endtask
`endif

  task automatic test_min_gt_max;
    enable = 1'b0;
    tick(1);
    smin = 14'sd500; smax = -14'sd500; div = 16'd0; enable = 1'b1;
    tick(3);
    n_chk++;
    if (state !== 3'd3 || val !== 14'sd500) begin
      n_fail++; $display("FAIL mgm_entry: state %0d val %0d want 3 500", state, val);
    end
    tick(3);
    n_chk++;
    if (val !== 14'sd500) begin
      n_fail++; $display("FAIL mgm_hold: val %0d want 500", val);
    end
  endtask

  task automatic test_async_reset;
    #2;
    rstn = 1'b0;
    #1;
    n_chk++;
    if (state !== 3'd0 || {freeze, ifreeze, int_rst, locked} !== 4'b0000 || val !== 14'sd0 || relock !== 16'd0) begin
      n_fail++; $display("FAIL async_reset: state %0d flags %b val %0d relock %0d want all 0", state, {freeze, ifreeze, int_rst, locked}, val, relock);
    end
    tick(1);
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_unlock();
    test_sweep();
    test_catch();
    test_enable_off();
    test_rail();
    test_sweep_div();
`ifdef LOCK_RELOCK_TIMEOUT_EN
    test_timeout();
`endif
    test_min_gt_max();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
